// File: rtl/pad_scan_pkg.sv
// -----------------------------------------------------------------------------
// pad_scan_pkg
// Shared constants and helpers for the 4x4 pad-matrix scanner.
//   NUM_ROWS / NUM_COLS / NUM_KEYS : matrix geometry (key index = row*4 + col)
//   DEFAULT_SCAN_DIV               : default cycles each row is driven
//   DEFAULT_DEBOUNCE_SCANS         : default disagreeing samples to flip a key
//   DWELL_W / DB_CNT_W / ROW_W     : counter widths sized for the legal
//                                    parameter ranges (SCAN_DIV <= 65535,
//                                    DEBOUNCE_SCANS <= 15)
// -----------------------------------------------------------------------------
package pad_scan_pkg;

    localparam int NUM_ROWS               = 4;
    localparam int NUM_COLS               = 4;
    localparam int NUM_KEYS               = NUM_ROWS * NUM_COLS;
    localparam int DEFAULT_SCAN_DIV       = 4;
    localparam int DEFAULT_DEBOUNCE_SCANS = 3;

    localparam int DWELL_W  = 16;
    localparam int DB_CNT_W = 4;
    localparam int ROW_W    = 2;

    typedef logic [NUM_KEYS-1:0] key_vec_t;

    // One-hot row drive pattern for a row index.
    function automatic logic [NUM_ROWS-1:0] row_onehot(input logic [ROW_W-1:0] row);
        logic [NUM_ROWS-1:0] vec;
        vec      = '0;
        vec[row] = 1'b1;
        return vec;
    endfunction

endpackage : pad_scan_pkg

// File: rtl/pad_debounce.sv
// -----------------------------------------------------------------------------
// pad_debounce
// Debouncer for a single key of the pad matrix. The key is only looked at when
// its row is sampled; a sample that disagrees with the debounced level bumps a
// counter, an agreeing sample clears it, and DEBOUNCE_SCANS disagreeing samples
// in a row flip the level and emit a one-cycle press or release pulse.
//
// Ports
//   clk          : system clock
//   rst          : asynchronous active-high reset
//   sample_en_i  : strobe, high in the sample cycle of this key's row
//   sample_i     : synchronized column level for this key
//   held_o       : registered debounced level
//   held_d_o     : next-state debounced level (lets the parent register OR-trees
//                  in step with held_o)
//   press_o      : one-cycle pulse on a debounced 0->1
//   release_o    : one-cycle pulse on a debounced 1->0 (tied low when
//                  RELEASE_EN is 0)
// -----------------------------------------------------------------------------
module pad_debounce
    import pad_scan_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = DEFAULT_DEBOUNCE_SCANS,
    parameter bit RELEASE_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_en_i,
    input  logic sample_i,
    output logic held_o,
    output logic held_d_o,
    output logic press_o,
    output logic release_o
);

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_SCANS - 1);

    logic [DB_CNT_W-1:0] cnt_q, cnt_d;
    logic                held_q, held_d;
    logic                press_q, press_d;
    logic                release_q, release_d;

    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        cnt_d     = cnt_q;
        held_d    = held_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sample_en_i) begin
            if (sample_i == held_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                // This disagreeing sample is the DEBOUNCE_SCANS-th: flip now.
                cnt_d     = '0;
                held_d    = ~held_q;
                press_d   = ~held_q;
                release_d = held_q & RELEASE_EN;
            end else begin
                cnt_d = cnt_q + DB_CNT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            held_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            held_q    <= held_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign held_o    = held_q;
    assign held_d_o  = held_d;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule : pad_debounce

// File: rtl/pad_scanner.sv
// -----------------------------------------------------------------------------
// pad_scanner
// Scans a 4x4 active-high key matrix: drives one row at a time for SCAN_DIV
// cycles (rows 0..3, no idle cycles), samples the synchronized columns in the
// last dwell cycle of each row and debounces every key independently.
//
// Ports
//   clk          : system clock, all state on its rising edge
//   rst          : asynchronous active-high reset
//   col_in[3:0]  : raw column sense, asynchronous to clk
//   row_drv[3:0] : one-hot row drive
//   key_held     : debounced key levels, index = row*4 + col
//   key_press    : one-cycle pulse per debounced 0->1
//   key_release  : one-cycle pulse per debounced 1->0
//   key_any      : OR of key_held
//   scan_frame   : one-cycle pulse in the cycle after row 3 is sampled
//
// Configuration
//   PAD_SCANNER_RELEASE_EN : when defined key_release pulses on releases;
//                            when undefined key_release is tied to 0.
// -----------------------------------------------------------------------------
module pad_scanner
    import pad_scan_pkg::*;
#(
    parameter int SCAN_DIV       = DEFAULT_SCAN_DIV,
    parameter int DEBOUNCE_SCANS = DEFAULT_DEBOUNCE_SCANS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_COLS-1:0] col_in,
    output logic [NUM_ROWS-1:0] row_drv,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                key_any,
    output logic                scan_frame
);

`ifdef PAD_SCANNER_RELEASE_EN
    localparam bit RELEASE_EN = 1'b1;
`else
    localparam bit RELEASE_EN = 1'b0;
`endif

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(NUM_ROWS - 1);

    // -------------------------------------------------------------------------
    // Column synchronizer
    // -------------------------------------------------------------------------
    logic [NUM_COLS-1:0] col_meta_q;
    logic [NUM_COLS-1:0] col_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta_q <= '0;
            col_sync_q <= '0;
        end else begin
            col_meta_q <= col_in;
            col_sync_q <= col_meta_q;
        end
    end

    // -------------------------------------------------------------------------
    // Row / dwell sequencer
    // -------------------------------------------------------------------------
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               frame_q, frame_d;
    logic               sample_w;

    assign sample_w = (dwell_q == DWELL_LAST);

    always_comb begin
        dwell_d = dwell_q + DWELL_W'(1);
        row_d   = row_q;
        frame_d = 1'b0;
        if (sample_w) begin
            dwell_d = '0;
            // Two-bit row index wraps 3 -> 0 on its own.
            row_d   = row_q + ROW_W'(1);
            frame_d = (row_q == LAST_ROW);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_q <= '0;
            row_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            dwell_q <= dwell_d;
            row_q   <= row_d;
            frame_q <= frame_d;
        end
    end

    // Decoded from a register, so row_drv is glitch-free and reads 0001 in reset.
    assign row_drv    = row_onehot(row_q);
    assign scan_frame = frame_q;

    // -------------------------------------------------------------------------
    // Per-key debouncers
    // -------------------------------------------------------------------------
    key_vec_t held_w;
    key_vec_t held_d_w;
    key_vec_t press_w;
    key_vec_t release_w;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        logic strobe_w;

        // Only the four keys of the row being sampled see a strobe; all other
        // debouncers hold their level and count.
        assign strobe_w = sample_w && (row_q == ROW_W'(k / NUM_COLS));

        pad_debounce #(
            .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
            .RELEASE_EN     (RELEASE_EN)
        ) u_debounce (
            .clk         (clk),
            .rst         (rst),
            .sample_en_i (strobe_w),
            .sample_i    (col_sync_q[k % NUM_COLS]),
            .held_o      (held_w[k]),
            .held_d_o    (held_d_w[k]),
            .press_o     (press_w[k]),
            .release_o   (release_w[k])
        );
    end

    // key_any is built from next-state levels so it changes on the same edge
    // as key_held rather than one cycle later.
    logic any_q, any_d;

    assign any_d = |held_d_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_q <= 1'b0;
        end else begin
            any_q <= any_d;
        end
    end

    assign key_held    = held_w;
    assign key_press   = press_w;
    assign key_release = release_w;
    assign key_any     = any_q;

endmodule : pad_scanner

// File: tb/tb_pad_scanner.sv
// -----------------------------------------------------------------------------
// tb_pad_scanner
// Self-checking bench for pad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3).
// A keypad emulation turns a 16-bit "pressed" vector into col_in for whichever
// row the scanner should be driving. A time-based reference model derives row,
// dwell and sample moments from the edge count since reset and debounces each
// key with plain per-key counters.
// -----------------------------------------------------------------------------
module tb_pad_scanner;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 3;
    localparam int FRAME          = SCAN_DIV * 4;

`ifdef PAD_SCANNER_RELEASE_EN
    localparam bit RELEASE_EN = 1'b1;
`else
    localparam bit RELEASE_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  col_in;
    logic [3:0]  row_drv;
    logic [15:0] key_held;
    logic [15:0] key_press;
    logic [15:0] key_release;
    logic        key_any;
    logic        scan_frame;

    pad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .col_in      (col_in),
        .row_drv     (row_drv),
        .key_held    (key_held),
        .key_press   (key_press),
        .key_release (key_release),
        .key_any     (key_any),
        .scan_frame  (scan_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    int          edges;          // rising edges since reset released
    logic [3:0]  col_hist[$];    // col_in values captured at past edges
    logic [15:0] m_held;
    logic [15:0] m_press;
    logic [15:0] m_rel;
    logic        m_frame;
    int          m_cnt[16];
    logic [15:0] pressed;        // keypad emulation: which keys are down

    always @(posedge clk) begin
        if (rst) begin
            edges = 0;
            col_hist.delete();
            col_hist.push_back(4'b0);
            col_hist.push_back(4'b0);
            m_held  = '0;
            m_press = '0;
            m_rel   = '0;
            m_frame = 1'b0;
            for (int i = 0; i < 16; i++) m_cnt[i] = 0;
        end else begin
            int         phase;
            int         row;
            logic [3:0] seen;
            phase   = edges % SCAN_DIV;
            row     = (edges / SCAN_DIV) % 4;
            // The column value visible to the scanner lags col_in by two edges.
            seen    = col_hist[col_hist.size() - 2];
            m_press = '0;
            m_rel   = '0;
            m_frame = 1'b0;
            if (phase == SCAN_DIV - 1) begin
                m_frame = (row == 3);
                for (int c = 0; c < 4; c++) begin
                    int k;
                    k = row * 4 + c;
                    if (seen[c] == m_held[k]) begin
                        m_cnt[k] = 0;
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                        if (m_cnt[k] == DEBOUNCE_SCANS) begin
                            m_cnt[k]  = 0;
                            m_held[k] = ~m_held[k];
                            if (m_held[k]) m_press[k] = 1'b1;
                            else           m_rel[k]   = RELEASE_EN;
                        end
                    end
                end
            end
            col_hist.push_back(col_in);
            if (col_hist.size() > 4) void'(col_hist.pop_front());
            edges = edges + 1;
        end
    end

    // Pulse counters gathered while ticking
    int frames_seen;
    int press5_seen;
    int rel0_seen;

    // One cycle: compare at the falling edge, then present the keypad columns
    // for the row being driven in this cycle.
    task automatic tick();
        int row;
        @(negedge clk);
        check("row_drv",     {28'b0, row_drv},    {28'b0, 4'b0001 << ((edges / SCAN_DIV) % 4)});
        check("key_held",    {16'b0, key_held},   {16'b0, m_held});
        check("key_press",   {16'b0, key_press},  {16'b0, m_press});
        check("key_release", {16'b0, key_release},{16'b0, m_rel});
        check("key_any",     {31'b0, key_any},    {31'b0, |m_held});
        check("scan_frame",  {31'b0, scan_frame}, {31'b0, m_frame});
        if (scan_frame)     frames_seen++;
        if (key_press[5])   press5_seen++;
        if (key_release[0]) rel0_seen++;
        row    = (edges / SCAN_DIV) % 4;
        col_in = pressed[row*4 +: 4];
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_row"},   {28'b0, row_drv},     32'h1);
        check({tag, "_held"},  {16'b0, key_held},    32'h0);
        check({tag, "_press"}, {16'b0, key_press},   32'h0);
        check({tag, "_rel"},   {16'b0, key_release}, 32'h0);
        check({tag, "_any"},   {31'b0, key_any},     32'h0);
        check({tag, "_frame"}, {31'b0, scan_frame},  32'h0);
    endtask

    initial begin
        rst     = 1'b1;
        col_in  = '0;
        pressed = '0;
        run(3);
        check_reset_outputs("reset");

        // Idle scan: row order, frame cadence, nothing held.
        rst = 1'b0;
        frames_seen = 0;
        run(4 * FRAME);
        check("idle_frames", frames_seen, 4);
        check("idle_held", {16'b0, key_held}, 32'h0);

        // Key 5 held steady: one press, nothing else.
        pressed     = 16'h0020;
        press5_seen = 0;
        run(5 * FRAME);
        check("k5_press_count", press5_seen, 1);
        check("k5_held", {16'b0, key_held}, 32'h0020);
        pressed = '0;
        run(4 * FRAME);
        check("k5_released", {16'b0, key_held}, 32'h0);

        // Key 5 toggling each row-1 sample never settles.
        press5_seen = 0;
        for (int i = 0; i < 4; i++) begin
            pressed = (i % 2 == 0) ? 16'h0020 : 16'h0000;
            run(FRAME);
        end
        pressed = '0;
        run(FRAME);
        check("toggle_press_count", press5_seen, 0);
        check("toggle_held", {16'b0, key_held}, 32'h0);

        // Corner keys 0 and 15 together.
        pressed = 16'h8001;
        run(4 * FRAME);
        check("corner_held", {16'b0, key_held}, 32'h8001);
        rel0_seen = 0;
        pressed   = '0;
        run(4 * FRAME);
        check("corner_released", {16'b0, key_held}, 32'h0);
        check("corner_rel_count", rel0_seen, RELEASE_EN ? 1 : 0);

        // Reset while key 5 is held, mid-scan.
        pressed = 16'h0020;
        run(5 * FRAME + 7);
        check("pre_rst_held", {16'b0, key_held}, 32'h0020);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        run(3);
        rst = 1'b0;
        press5_seen = 0;
        run(4 * FRAME);
        check("repress_count", press5_seen, 1);
        check("repress_held", {16'b0, key_held}, 32'h0020);

        // Randomized key patterns with random hold lengths and bouncy edges.
        for (int r = 0; r < 24; r++) begin
            int bounce;
            bounce = $urandom_range(0, 6);
            for (int b = 0; b < bounce; b++) begin
                pressed = 16'($urandom);
                run($urandom_range(1, 5));
            end
            pressed = 16'($urandom);
            if (r % 5 == 0) pressed = 16'hffff;
            run($urandom_range(1, 4) * FRAME + $urandom_range(0, FRAME - 1));
        end
        pressed = '0;
        run(4 * FRAME);
        check("final_idle", {16'b0, key_held}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pad_scanner
